// File: rtl/tt_puf_challenger_if.sv
// Host-side run/response handshake of the PUF challenger.
// master = challenger, slave = consumer of the response word.
interface tt_puf_challenger_if #(
    parameter int unsigned RESP_BITS = 16
) ();
    logic                 start;
    logic [3:0]           seed;
    logic                 busy;
    logic [RESP_BITS-1:0] resp_out;
    logic                 resp_valid;
    logic                 resp_ready;

    modport master (
        input  start,
        input  seed,
        input  resp_ready,
        output busy,
        output resp_out,
        output resp_valid
    );

    modport slave (
        output start,
        output seed,
        output resp_ready,
        input  busy,
        input  resp_out,
        input  resp_valid
    );
endinterface

// File: rtl/tt_puf_challenger.sv
// Challenge sequencer for a keyed delay-chain arbiter PUF; builds a RESP_BITS response word.
// Optional TT_PUF_MAJ_VOTE_EN: three shots per challenge, majority-voted result bit.
module tt_puf_challenger #(
    parameter int unsigned RESP_BITS  = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    tt_puf_challenger_if.master host,
    output logic                pulse,
    output logic [3:0]          key_4,
    input  logic                resp_in
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArm    = 3'd1;
    localparam logic [2:0] StFire   = 3'd2;
    localparam logic [2:0] StSample = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam int unsigned PhW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned KW  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0]  KLast  = KW'(RESP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [PhW-1:0]       phase_q, phase_d;
    logic [KW-1:0]        bit_q, bit_d;
    logic [3:0]           seed_q, seed_d;
    logic [RESP_BITS-1:0] resp_out_q, resp_out_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 last_shot;
    logic                 sample_bit;

`ifdef TT_PUF_MAJ_VOTE_EN
    logic [1:0] shot_q, shot_d;
    logic [1:0] vote_q, vote_d;
    logic [1:0] vote_sum;

    // vote_q never exceeds 2 before the third sample, so the sum fits in 2 bits
    assign vote_sum   = vote_q + {1'b0, sync2_q};
    assign last_shot  = (shot_q == 2'd2);
    assign sample_bit = vote_sum[1];
`else
    assign last_shot  = 1'b1;
    assign sample_bit = sync2_q;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        seed_d     = seed_q;
        resp_out_d = resp_out_q;
        sync1_d    = resp_in;
        sync2_d    = sync1_q;
`ifdef TT_PUF_MAJ_VOTE_EN
        shot_d     = shot_q;
        vote_d     = vote_q;
`endif
        case (state_q)
            StIdle: begin
                if (host.start) begin
                    seed_d     = host.seed;
                    resp_out_d = '0;
                    bit_d      = '0;
                    phase_d    = '0;
                    state_d    = StArm;
`ifdef TT_PUF_MAJ_VOTE_EN
                    shot_d     = 2'd0;
                    vote_d     = 2'd0;
`endif
                end
            end
            StArm: begin
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    state_d = StFire;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StFire: begin
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    state_d = StSample;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StSample: begin
                state_d = StArm;
`ifdef TT_PUF_MAJ_VOTE_EN
                if (last_shot) begin
                    shot_d = 2'd0;
                    vote_d = 2'd0;
                end else begin
                    shot_d = shot_q + 2'd1;
                    vote_d = vote_sum;
                end
`endif
                if (last_shot) begin
                    resp_out_d[bit_q] = sample_bit;
                    if (bit_q == KLast) begin
                        state_d = StDone;
                    end else begin
                        bit_d = bit_q + KW'(1);
                    end
                end
            end
            StDone: begin
                if (host.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bit_q      <= '0;
            seed_q     <= '0;
            resp_out_q <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
`ifdef TT_PUF_MAJ_VOTE_EN
            shot_q     <= 2'd0;
            vote_q     <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            seed_q     <= seed_d;
            resp_out_q <= resp_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
`ifdef TT_PUF_MAJ_VOTE_EN
            shot_q     <= shot_d;
            vote_q     <= vote_d;
`endif
        end
    end

    // key_4 is forced to 0 only in IDLE; DONE keeps showing the last challenge
    assign key_4           = (state_q == StIdle) ? 4'd0 : (seed_q + 4'(bit_q));
    assign pulse           = (state_q == StFire) || (state_q == StSample);
    assign host.busy       = (state_q != StIdle);
    assign host.resp_valid = (state_q == StDone);
    assign host.resp_out   = resp_out_q;

endmodule

// File: tb/tb_tt_puf_challenger.sv
// Scoreboard bench for tt_puf_challenger: runs push expected words, a negedge monitor checks them.
module tb_tt_puf_challenger;

    localparam int unsigned RespBits  = 16;
    localparam int unsigned SettleCyc = 8;
`ifdef TT_PUF_MAJ_VOTE_EN
    localparam int Shots = 3;
`else
    localparam int Shots = 1;
`endif
    localparam int BitPer = Shots * (2 * SettleCyc + 1);
    localparam int RunCyc = RespBits * BitPer;

    typedef struct {
        logic [15:0] word;
        int          valid_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse;
    logic [3:0] key_4;
    logic       resp_in;

    tt_puf_challenger_if #(.RESP_BITS(RespBits)) host_if ();

    tt_puf_challenger #(
        .RESP_BITS (RespBits),
        .SETTLE_CYC(SettleCyc)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .host   (host_if),
        .pulse  (pulse),
        .key_4  (key_4),
        .resp_in(resp_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t dropped;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    endfunction

    // Responder: 0 = constant, 1 = key-dependent while racing, 2 = per-shot vote pattern
    int         mode = 0;
    logic       resp_const = 1'b0;
    logic [2:0] vote_pat = 3'b000;
    logic [1:0] shot = 2'd0;
    logic       shot_clr = 1'b1;
    logic       pulse_seen = 1'b0;

    always_comb begin
        case (mode)
            0:       resp_in = resp_const;
            1:       resp_in = pulse & key_4[0];
            default: resp_in = vote_pat[shot];
        endcase
    end

    always @(negedge clk) begin
        if (shot_clr) shot <= 2'd0;
        else if (pulse_seen && !pulse) shot <= (shot == 2'd2) ? 2'd0 : shot + 2'd1;
        pulse_seen <= pulse;
    end

    // Monitor: every rising resp_valid consumes one scoreboard entry
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (host_if.resp_valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_valid: resp_out %0h with empty scoreboard", host_if.resp_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_out", 32'(host_if.resp_out), 32'(mon_e.word));
                check("valid_cycle", cyc, mon_e.valid_cyc);
            end
        end
        valid_prev <= host_if.resp_valid;
    end

    task automatic start_run(input logic [3:0] s, input logic [15:0] w);
        exp_t e;
        @(negedge clk);
        host_if.seed  = s;
        host_if.start = 1'b1;
        @(negedge clk);
        host_if.start = 1'b0;
        e.word      = w;
        e.valid_cyc = cyc + RunCyc;
        exp_q.push_back(e);
    endtask

    // Called on the first ARM cycle; returns on the first DONE cycle
    task automatic watch_run(input logic [3:0] s);
        for (int b = 0; b < int'(RespBits); b++) begin
            int         cnt;
            logic [3:0] ek;
            cnt = 0;
            ek  = s + 4'(b);
            for (int c = 0; c < BitPer; c++) begin
                if (c == 0) check("key_step", 32'(key_4), 32'(ek));
                if (pulse) cnt++;
                @(negedge clk);
            end
            check("pulse_len", cnt, Shots * (SettleCyc + 1));
        end
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        while (!host_if.resp_valid && waited < RunCyc + 50) begin
            @(negedge clk);
            waited++;
        end
        if (!host_if.resp_valid) begin
            chk_cnt++;
            $display("FAIL valid_timeout: resp_valid %0b after %0d cycles, required 1",
                     host_if.resp_valid, waited);
        end
    endtask

    task automatic finish_run();
        wait_valid();
        host_if.resp_ready = 1'b1;
        @(negedge clk);
        host_if.resp_ready = 1'b0;
        check("busy_after_ack", 32'(host_if.busy), 0);
    endtask

    task automatic check_idle_zero(string tag);
        check({tag, "_pulse"}, 32'(pulse), 0);
        check({tag, "_key"}, 32'(key_4), 0);
        check({tag, "_busy"}, 32'(host_if.busy), 0);
        check({tag, "_valid"}, 32'(host_if.resp_valid), 0);
        check({tag, "_resp"}, 32'(host_if.resp_out), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst                = 1'b1;
        host_if.start      = 1'b1;
        host_if.seed       = 4'h5;
        host_if.resp_ready = 1'b0;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_zero("reset");
        end
        rst           = 1'b0;
        host_if.start = 1'b0;
        shot_clr      = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(host_if.busy), 0);

`ifdef TT_PUF_MAJ_VOTE_EN
        mode     = 2;
        vote_pat = 3'b101;
        start_run(4'h0, 16'hFFFF);
        finish_run();
        vote_pat = 3'b010;
        start_run(4'h0, 16'h0000);
        finish_run();
`endif

        // Constant response, key stepping and pulse width
        mode       = 0;
        resp_const = 1'b1;
        start_run(4'h0, 16'hFFFF);
        watch_run(4'h0);
        finish_run();

        // Key-dependent responder, seed 3 wraps 15 -> 0; late seed change ignored
        mode = 1;
        start_run(4'h3, 16'h5555);
        host_if.seed = 4'hC;
        watch_run(4'h3);
        check("key_hold_done", 32'(key_4), 32'h2);
        finish_run();

        // resp_ready high while idle has no effect; seed 0 gives alternating bits
        host_if.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_idle_busy", 32'(host_if.busy), 0);
        start_run(4'h0, 16'hAAAA);
        wait_valid();
        @(negedge clk);
        check("auto_ack_valid", 32'(host_if.resp_valid), 0);
        check("auto_ack_busy", 32'(host_if.busy), 0);
        host_if.resp_ready = 1'b0;

        // Backpressure with start pulses in DONE
        start_run(4'h3, 16'h5555);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 32'(host_if.resp_valid), 1);
            check("bp_resp", 32'(host_if.resp_out), 32'h5555);
            host_if.start = i[0];
            @(negedge clk);
        end
        host_if.start      = 1'b1;
        host_if.resp_ready = 1'b1;
        @(negedge clk);
        host_if.start      = 1'b0;
        host_if.resp_ready = 1'b0;
        check("bp_ack_busy", 32'(host_if.busy), 0);
        check("bp_ack_valid", 32'(host_if.resp_valid), 0);
        @(negedge clk);
        check("bp_no_queue", 32'(host_if.busy), 0);
        check("idle_resp_hold", 32'(host_if.resp_out), 32'h5555);

        // Mid-run reset discards the partial run
        mode       = 0;
        resp_const = 1'b1;
        start_run(4'h0, 16'hFFFF);
        n = cyc;
        while (cyc < n + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midrst");
        dropped = exp_q.pop_back();
        start_run(4'h0, 16'hFFFF);
        finish_run();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
